// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter in front of a single shared 8-bit ALU.
// The winning operation is computed combinationally and captured in a one-deep
// result register. That register drains to one consumer over valid/ready.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_opcode,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [8*NUM_REQ-1:0] req_c,
    input  logic [8*NUM_REQ-1:0] req_d,
    input  logic [NUM_REQ-1:0]   req_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_result,
    output logic                 out_zero,
    output logic [IDW-1:0]       out_id,
    output logic [15:0]          ops_done
);
    localparam int PW = $clog2(NUM_REQ);

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic       sel;
    } op_req_t;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    op_req_t       lane [NUM_REQ];
    op_req_t       win_req;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] cand;
    logic [PW-1:0] next_ptr;
    logic          found;
    logic          accept;
    logic [7:0]    alu_res;
    int            pos;

    // Unpack the flat per-requester buses into one struct per lane
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = {req_opcode[4*g +: 4], req_a[8*g +: 8], req_b[8*g +: 8],
                          req_c[8*g +: 8], req_d[8*g +: 8], req_sel[g]};
    end

    assign out_valid = (state == FULL);
    // Reset gates the accept so no grant is ever shown while rst_n is low
    assign accept    = rst_n && (!out_valid || out_ready) && found;
    assign win_req   = lane[winner];
    assign next_ptr  = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // Round-robin search: first valid requester starting at ptr, wrapping
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = PW'(pos);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // One-hot grant at the winner, only on a real accept
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    // Shared ALU datapath; everything is mod 256
    always_comb begin
        alu_res = '0;
        case (win_req.opcode)
            4'b0000, 4'b0111: alu_res = win_req.a + win_req.b + win_req.c + win_req.d;
            4'b0001:          alu_res = win_req.a - win_req.b;
            4'b0010:          alu_res = win_req.a & win_req.b;
            4'b0011:          alu_res = win_req.a | win_req.b;
            4'b0100:          alu_res = win_req.a ^ win_req.b;
            4'b0101:          alu_res = ~win_req.a;
            4'b0110:          alu_res = win_req.sel ? (win_req.a + win_req.c)
                                                    : (win_req.b + win_req.d);
            default:          alu_res = '0;
        endcase
    end

    // Result register FSM: a FULL register reloads on drain+accept with no bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_id     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_result <= alu_res;
                        out_zero   <= (alu_res == 8'h00);
                        out_id     <= IDW'(winner);
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_result <= alu_res;
                        out_zero   <= (alu_res == 8'h00);
                        out_id     <= IDW'(winner);
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Pointer advances past the winner only when something is accepted
    always_ff @(posedge clk) begin
        if (!rst_n)      ptr <= '0;
        else if (accept) ptr <= next_ptr;
    end

    // Completed output handshakes, free-running modulo 2^16
    always_ff @(posedge clk) begin
        if (!rst_n)                      ops_done <= '0;
        else if (out_valid && out_ready) ops_done <= ops_done + 16'd1;
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: a negedge monitor keeps a reference model and a
// result scoreboard; scenario tasks add targeted checks with fixed expectations.
module tb_alu_rr_scheduler;
    localparam int N = 4;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic [2:0] id;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '1;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_opcode = '0;
    logic [8*N-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [N-1:0]   req_sel = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [7:0]     out_result;
    logic           out_zero;
    logic [2:0]     out_id;
    logic [15:0]    ops_done;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    int   m_ptr = 0;
    logic m_full = 1'b0;
    logic [15:0] m_ops = '0;

    alu_rr_scheduler #(.NUM_REQ(N), .IDW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_d(req_d), .req_sel(req_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_id(out_id), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c,
                                             input logic [7:0] d, input logic s);
        case (op)
            4'd0, 4'd7: return a + b + c + d;
            4'd1:       return a - b;
            4'd2:       return a & b;
            4'd3:       return a | b;
            4'd4:       return a ^ b;
            4'd5:       return ~a;
            4'd6:       return s ? a + c : b + d;
            default:    return 8'h00;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                           input logic s);
        req_opcode[i*4 +: 4] = op;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
        req_d[i*8 +: 8] = d;
        req_sel[i] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reference model of grant, output state, counter and scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_checks++;
                if (req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL mon_ready_in_reset: got %b expected 0000", req_ready);
                end
                m_ptr = 0;
                m_full = 1'b0;
                m_ops = '0;
                sbq.delete();
            end else begin
                logic       acc;
                logic [N-1:0] exp_rdy;
                int         w;
                exp_t       e;
                n_checks++;
                if (out_valid !== m_full) begin
                    n_fail++;
                    $display("FAIL mon_out_valid: got %b expected %b", out_valid, m_full);
                end
                n_checks++;
                if (ops_done !== m_ops) begin
                    n_fail++;
                    $display("FAIL mon_ops_done: got %h expected %h", ops_done, m_ops);
                end
                if (m_full && out_ready) begin
                    n_checks++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_scoreboard_empty: got handshake expected none");
                    end else begin
                        e = sbq.pop_front();
                        if (out_result !== e.res || out_zero !== e.z || out_id !== e.id) begin
                            n_fail++;
                            $display("FAIL mon_result: got r=%h z=%b id=%0d expected r=%h z=%b id=%0d",
                                     out_result, out_zero, out_id, e.res, e.z, e.id);
                        end
                    end
                    m_ops++;
                end
                acc = (!m_full || out_ready) && (|req_valid);
                exp_rdy = '0;
                if (acc) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_ptr + k) % N;
                        if (w < 0 && req_valid[idx]) w = idx;
                    end
                    exp_rdy[w] = 1'b1;
                    e.res = alu_model(req_opcode[w*4 +: 4], req_a[w*8 +: 8], req_b[w*8 +: 8],
                                      req_c[w*8 +: 8], req_d[w*8 +: 8], req_sel[w]);
                    e.z = (e.res == 8'h00);
                    e.id = 3'(w);
                    sbq.push_back(e);
                    m_ptr = (w + 1) % N;
                    m_full = 1'b1;
                end else if (out_ready) begin
                    m_full = 1'b0;
                end
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL mon_req_ready: got %b expected %b", req_ready, exp_rdy);
                end
            end
        end
    end

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b0 || ops_done !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b ops=%h expected 0000 0 0000",
                     req_ready, out_valid, ops_done);
        end
        n_checks++;
        if (out_result !== 8'h00 || out_zero !== 1'b0 || out_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got r=%h z=%b id=%0d expected 00 0 0",
                     out_result, out_zero, out_id);
        end
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_arith();
        set_req(2, 4'b0000, 8'h80, 8'h80, 8'h01, 8'hFF, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL arith_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 8'h00 || out_zero !== 1'b1 || out_id !== 3'd2) begin
            n_fail++;
            $display("FAIL arith_sum_wrap: got v=%b r=%h z=%b id=%0d expected 1 00 1 2",
                     out_valid, out_result, out_zero, out_id);
        end
        tick();
        set_req(2, 4'b0110, 8'h11, 8'h10, 8'h22, 8'h25, 1'b0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_result !== 8'h35 || out_zero !== 1'b0 || out_id !== 3'd2) begin
            n_fail++;
            $display("FAIL arith_sel0: got r=%h z=%b id=%0d expected 35 0 2",
                     out_result, out_zero, out_id);
        end
        tick();
        // Every opcode, including the unused ones, from a random requester
        for (int op = 0; op < 16; op++) begin
            int id;
            logic [N-1:0] onehot;
            id = $urandom_range(0, N - 1);
            onehot = '0;
            onehot[id] = 1'b1;
            set_req(id, 4'(op), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom));
            req_valid = onehot;
            @(negedge clk);
            n_checks++;
            if (req_ready !== onehot) begin
                n_fail++;
                $display("FAIL arith_op_grant: got %b expected %b", req_ready, onehot);
            end
            tick();
            req_valid = '0;
            if (op >= 8) begin
                @(negedge clk);
                n_checks++;
                if (out_result !== 8'h00 || out_zero !== 1'b1) begin
                    n_fail++;
                    $display("FAIL arith_unused_op: got r=%h z=%b expected 00 1", out_result, out_zero);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'b0011, 8'(i), 8'h40, 8'h00, 8'h00, 1'b0);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] exp_g;
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got %b expected %b", k, req_ready, exp_g);
            end
            if (k >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_back_to_back_%0d: got out_valid=%b expected 1", k, out_valid);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt;
        set_req(0, 4'b0100, 8'h50, 8'h0A, 8'h00, 8'h00, 1'b0);
        set_req(1, 4'b0011, 8'h0F, 8'hA0, 8'h00, 8'h00, 1'b0);
        set_req(2, 4'b0101, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(3, 4'b0001, 8'h09, 8'h04, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_no_grant_%0d: got %b expected 0000", k, req_ready);
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== 8'h5A || out_zero !== 1'b0 || out_id !== 3'd0) begin
                n_fail++;
                $display("FAIL bp_frozen_%0d: got v=%b r=%h z=%b id=%0d expected 1 5a 0 0",
                         k, out_valid, out_result, out_zero, out_id);
            end
            tick();
        end
        cnt = m_ops;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_same_cycle_accept: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (ops_done !== cnt + 16'd1 || out_result !== 8'hAF || out_id !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_drain: got ops=%h r=%h id=%0d expected %h af 1",
                     ops_done, out_result, out_id, cnt + 16'd1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(2, 4'b0011, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pending: got out_valid=%b expected 1", out_valid);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1100;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || ops_done !== 16'h0000 || out_result !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_discard: got v=%b ops=%h r=%h expected 0 0000 00",
                     out_valid, ops_done, out_result);
        end
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_first_grant: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_counter_wrap();
        logic hit;
        hit = 1'b0;
        set_req(0, 4'b0010, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (ops_done === 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wrap_reach_ffff: got %h expected ffff within budget", ops_done);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (ops_done !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_to_zero: got %h expected 0000", ops_done);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
